// File: rtl/speed_meter_nch.sv
// speed_meter_nch: multi-channel pulse-rate meter with gated counting and serial BCD conversion.
// Defining SPEED_DEBOUNCE_EN inserts a 4-sample glitch filter ahead of each edge detector.
module speed_meter_nch #(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 12,
    parameter int GATE_CYCLES = 100000000,
    parameter int SHIFT       = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       speed_pulse,
    output logic [N_CH*CNT_W-1:0] speed_bin,
    output logic [N_CH*12-1:0]    speed_bcd,
    output logic [N_CH-1:0]       ovf,
    output logic                  data_valid
);
    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] level_d;
    logic [N_CH-1:0] pulse_edge;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= speed_pulse;
            sync2 <= sync1;
        end
    end

`ifdef SPEED_DEBOUNCE_EN
    logic [N_CH-1:0][1:0] stable_cnt;
    logic [N_CH-1:0]      filt;

    // The filtered level follows only after four consecutive samples disagree with it.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            filt       <= '0;
            stable_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync2[i] == filt[i]) begin
                    stable_cnt[i] <= 2'd0;
                end else if (stable_cnt[i] == 2'd3) begin
                    filt[i]       <= sync2[i];
                    stable_cnt[i] <= 2'd0;
                end else begin
                    stable_cnt[i] <= stable_cnt[i] + 2'd1;
                end
            end
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            level_d <= '0;
        end else begin
            level_d <= level;
        end
    end

    assign pulse_edge = level & ~level_d;

    logic [GATE_W-1:0] gate_cnt;
    logic              window_end;

    assign window_end = (gate_cnt == GATE_LAST);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            gate_cnt <= '0;
        end else if (window_end) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
        end
    end

    logic [N_CH-1:0][CNT_W-1:0] cnt;
    logic [N_CH-1:0]            sticky;
    logic [N_CH-1:0]            sat_hit;

    // An edge arriving while the counter is already full is the overflow event.
    always_comb begin
        sat_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            sat_hit[i] = pulse_edge[i] && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt       <= '0;
            sticky    <= '0;
            speed_bin <= '0;
            ovf       <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (window_end) begin
                    speed_bin[i*CNT_W +: CNT_W] <= (pulse_edge[i] && !sat_hit[i]) ?
                                                   cnt[i] + CNT_W'(1) : cnt[i];
                    ovf[i]    <= sticky[i] | sat_hit[i];
                    cnt[i]    <= '0;
                    sticky[i] <= 1'b0;
                end else if (pulse_edge[i]) begin
                    if (sat_hit[i]) begin
                        sticky[i] <= 1'b1;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [3:0]       iter;
    logic [9:0]       bin_sr;
    logic [11:0]      bcd_sr;
    logic [CNT_W-1:0] sel_bin;
    logic [CNT_W-1:0] shifted;
    logic [9:0]       operand;
    logic [11:0]      bcd_adj;
    logic [11:0]      bcd_next;
    logic [9:0]       bin_next;

    // Operand selection with display clipping, plus one double-dabble step.
    always_comb begin
        sel_bin = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(idx) == i) begin
                sel_bin = speed_bin[i*CNT_W +: CNT_W];
            end
        end
        shifted = sel_bin >> SHIFT;
        operand = (shifted > CNT_W'(999)) ? 10'd999 : shifted[9:0];
        bcd_adj = bcd_sr;
        for (int d = 0; d < 3; d++) begin
            if (bcd_sr[d*4 +: 4] >= 4'd5) begin
                bcd_adj[d*4 +: 4] = bcd_sr[d*4 +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[10:0], bin_sr[9]};
        bin_next = {bin_sr[8:0], 1'b0};
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            iter       <= '0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            speed_bcd  <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (window_end) begin
                        idx   <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bin_sr <= operand;
                    bcd_sr <= '0;
                    iter   <= '0;
                    state  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bin_sr <= bin_next;
                    bcd_sr <= bcd_next;
                    iter   <= iter + 4'd1;
                    if (iter == 4'd9) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (int'(idx) == i) begin
                                speed_bcd[i*12 +: 12] <= bcd_next;
                            end
                        end
                        if (int'(idx) == N_CH - 1) begin
                            data_valid <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speed_meter_nch.sv
// Directed bench for speed_meter_nch: three instances cover normal counting, saturation and clipping.
// Expectations follow SPEED_DEBOUNCE_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_speed_meter_nch;
`ifdef SPEED_DEBOUNCE_EN
    localparam int LAT    = 6;
    localparam int HP     = 5;
    localparam int GATE_A = 3000;
    localparam int GATE_B = 12000;
    localparam int GATE_C = 16000;
    localparam int GLITCH_EXP = 10;
    localparam logic [11:0] GLITCH_BCD = 12'h005;
`else
    localparam int LAT    = 2;
    localparam int HP     = 2;
    localparam int GATE_A = 1000;
    localparam int GATE_B = 5000;
    localparam int GATE_C = 7000;
    localparam int GLITCH_EXP = 15;
    localparam logic [11:0] GLITCH_BCD = 12'h007;
`endif
    // Cycles from the window-end cycle to data_valid for two channels.
    localparam int CONV = 23;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, rst_b, rst_c;
    logic [1:0]  pulse_a, pulse_b, pulse_c;
    logic [23:0] bin_a;
    logic [19:0] bin_b;
    logic [23:0] bin_c;
    logic [23:0] bcd_a, bcd_b, bcd_c;
    logic [1:0]  ovf_a, ovf_b, ovf_c;
    logic        dv_a, dv_b, dv_c;

    int checks = 0;
    int errors = 0;
    int rel_a, rel_b, rel_c;

    speed_meter_nch #(.N_CH(2), .CNT_W(12), .GATE_CYCLES(GATE_A), .SHIFT(1)) dut_a (
        .clk_in(clk), .rst_n(rst_a), .speed_pulse(pulse_a),
        .speed_bin(bin_a), .speed_bcd(bcd_a), .ovf(ovf_a), .data_valid(dv_a)
    );

    speed_meter_nch #(.N_CH(2), .CNT_W(10), .GATE_CYCLES(GATE_B), .SHIFT(1)) dut_b (
        .clk_in(clk), .rst_n(rst_b), .speed_pulse(pulse_b),
        .speed_bin(bin_b), .speed_bcd(bcd_b), .ovf(ovf_b), .data_valid(dv_b)
    );

    speed_meter_nch #(.N_CH(2), .CNT_W(12), .GATE_CYCLES(GATE_C), .SHIFT(0)) dut_c (
        .clk_in(clk), .rst_n(rst_c), .speed_pulse(pulse_c),
        .speed_bin(bin_c), .speed_bcd(bcd_c), .ovf(ovf_c), .data_valid(dv_c)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rel(input int rel, input int c);
        while (cyc - rel < c) @(negedge clk);
    endtask

    task automatic pulses_a(input int n0, input int n1);
        int n;
        n = (n0 > n1) ? n0 : n1;
        for (int i = 0; i < n; i++) begin
            pulse_a[0] = (i < n0);
            pulse_a[1] = (i < n1);
            tick(HP);
            pulse_a = 2'b00;
            tick(HP);
        end
    endtask

    task automatic pulses_b(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_b[0] = 1'b1;
            tick(HP);
            pulse_b[0] = 1'b0;
            tick(HP);
        end
    endtask

    task automatic pulses_c(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_c[0] = 1'b1;
            tick(HP);
            pulse_c[0] = 1'b0;
            tick(HP);
        end
    endtask

    // Returns the cycle index (relative to rel) at which data_valid is seen, or -1.
    task automatic wait_dv(input int which, input int rel, input int limit, output int at_c);
        logic dv;
        at_c = -1;
        for (int k = 0; k < limit; k++) begin
            dv = (which == 0) ? dv_a : ((which == 1) ? dv_b : dv_c);
            if (dv) begin
                at_c = cyc - rel;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        tick(5);
        checks++;
        if ({bin_a, bcd_a, ovf_a, dv_a} !== 51'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_a: got bin=%h bcd=%h ovf=%b dv=%b want all 0",
                     bin_a, bcd_a, ovf_a, dv_a);
        end
        checks++;
        if ({dv_b, dv_c, ovf_b, ovf_c} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_bc: got dv=%b%b ovf=%b/%b want 0", dv_b, dv_c, ovf_b, ovf_c);
        end
    endtask

    task automatic test_basic();
        int at_c;
        rst_a = 1'b1;
        rel_a = cyc;
        wait_rel(rel_a, 10);
        pulses_a(200, 57);
        wait_dv(0, rel_a, GATE_A + 100, at_c);
        checks++;
        if (at_c !== GATE_A - 1 + CONV) begin
            errors++;
            $display("[TB] FAIL basic_dv_time: got %0d want %0d", at_c, GATE_A - 1 + CONV);
        end
        checks++;
        if (bin_a !== {12'd57, 12'd200}) begin
            errors++;
            $display("[TB] FAIL basic_bin: got %h want %h", bin_a, {12'd57, 12'd200});
        end
        checks++;
        if (bcd_a !== {12'h028, 12'h100}) begin
            errors++;
            $display("[TB] FAIL basic_bcd: got %h want %h", bcd_a, {12'h028, 12'h100});
        end
        checks++;
        if (ovf_a !== 2'b00) begin
            errors++;
            $display("[TB] FAIL basic_ovf: got %b want 00", ovf_a);
        end
        tick(1);
        checks++;
        if (dv_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_dv_width: got %b want 0", dv_a);
        end
    endtask

    task automatic test_we_boundary();
        int at_c;
        wait_rel(rel_a, GATE_A + 40);
        pulses_a(7, 4);
        // ch0 edge lands in the window-end cycle, ch1 edge one cycle later.
        wait_rel(rel_a, 2 * GATE_A - 1 - LAT);
        pulse_a[0] = 1'b1;
        tick(1);
        pulse_a[1] = 1'b1;
        tick(HP + 1);
        pulse_a = 2'b00;
        wait_dv(0, rel_a, GATE_A, at_c);
        checks++;
        if (at_c !== 2 * GATE_A - 1 + CONV) begin
            errors++;
            $display("[TB] FAIL we_dv_time: got %0d want %0d", at_c, 2 * GATE_A - 1 + CONV);
        end
        checks++;
        if (bin_a !== {12'd4, 12'd8}) begin
            errors++;
            $display("[TB] FAIL we_old_window_bin: got %h want %h", bin_a, {12'd4, 12'd8});
        end
        checks++;
        if (bcd_a !== {12'h002, 12'h004}) begin
            errors++;
            $display("[TB] FAIL we_old_window_bcd: got %h want %h", bcd_a, {12'h002, 12'h004});
        end
        wait_rel(rel_a, 2 * GATE_A + 30);
        pulses_a(40, 10);
        wait_dv(0, rel_a, GATE_A + 100, at_c);
        checks++;
        if (at_c !== 3 * GATE_A - 1 + CONV) begin
            errors++;
            $display("[TB] FAIL we_next_dv_time: got %0d want %0d", at_c, 3 * GATE_A - 1 + CONV);
        end
        checks++;
        if (bin_a !== {12'd11, 12'd40}) begin
            errors++;
            $display("[TB] FAIL we_new_window_bin: got %h want %h", bin_a, {12'd11, 12'd40});
        end
        checks++;
        if (bcd_a !== {12'h005, 12'h020}) begin
            errors++;
            $display("[TB] FAIL we_new_window_bcd: got %h want %h", bcd_a, {12'h005, 12'h020});
        end
    endtask

    task automatic test_reset_abort();
        int at_c;
        wait_rel(rel_a, 3 * GATE_A + 40);
        pulses_a(20, 6);
        wait_rel(rel_a, 4 * GATE_A + 1);
        checks++;
        if (bin_a !== {12'd6, 12'd20} || bcd_a !== {12'h005, 12'h020}) begin
            errors++;
            $display("[TB] FAIL abort_pre_state: got bin=%h bcd=%h want bin=%h bcd=%h",
                     bin_a, bcd_a, {12'd6, 12'd20}, {12'h005, 12'h020});
        end
        // Reset is sampled low at the end of cycle WE+5 only.
        wait_rel(rel_a, 4 * GATE_A + 4);
        rst_a = 1'b0;
        tick(1);
        checks++;
        if ({bin_a, bcd_a, ovf_a, dv_a} !== 51'd0) begin
            errors++;
            $display("[TB] FAIL abort_cleared: got bin=%h bcd=%h ovf=%b dv=%b want all 0",
                     bin_a, bcd_a, ovf_a, dv_a);
        end
        rst_a = 1'b1;
        rel_a = cyc;
        wait_dv(0, rel_a, GATE_A + 100, at_c);
        checks++;
        if (at_c !== GATE_A - 1 + CONV) begin
            errors++;
            $display("[TB] FAIL abort_next_dv_time: got %0d want %0d", at_c, GATE_A - 1 + CONV);
        end
        checks++;
        if ({bin_a, bcd_a} !== 48'd0) begin
            errors++;
            $display("[TB] FAIL abort_empty_window: got bin=%h bcd=%h want 0", bin_a, bcd_a);
        end
    endtask

    task automatic test_glitch();
        int at_c;
        wait_rel(rel_a, GATE_A + 40);
        for (int g = 0; g < 5; g++) begin
            pulse_a[0] = 1'b1;
            tick(2);
            pulse_a[0] = 1'b0;
            tick(6);
        end
        pulses_a(10, 0);
        wait_dv(0, rel_a, GATE_A + 100, at_c);
        checks++;
        if (at_c !== 2 * GATE_A - 1 + CONV) begin
            errors++;
            $display("[TB] FAIL glitch_dv_time: got %0d want %0d", at_c, 2 * GATE_A - 1 + CONV);
        end
        checks++;
        if (bin_a !== {12'd0, 12'(GLITCH_EXP)}) begin
            errors++;
            $display("[TB] FAIL glitch_count: got %h want %h", bin_a, {12'd0, 12'(GLITCH_EXP)});
        end
        checks++;
        if (bcd_a[11:0] !== GLITCH_BCD) begin
            errors++;
            $display("[TB] FAIL glitch_bcd: got %h want %h", bcd_a[11:0], GLITCH_BCD);
        end
    endtask

    task automatic test_saturate();
        int at_c;
        rst_b = 1'b1;
        rel_b = cyc;
        wait_rel(rel_b, 10);
        pulses_b(1100);
        wait_dv(1, rel_b, GATE_B + 100, at_c);
        checks++;
        if (at_c !== GATE_B - 1 + CONV) begin
            errors++;
            $display("[TB] FAIL sat_dv_time: got %0d want %0d", at_c, GATE_B - 1 + CONV);
        end
        checks++;
        if (bin_b !== {10'd0, 10'd1023}) begin
            errors++;
            $display("[TB] FAIL sat_bin: got %h want %h", bin_b, {10'd0, 10'd1023});
        end
        checks++;
        if (ovf_b !== 2'b01) begin
            errors++;
            $display("[TB] FAIL sat_ovf: got %b want 01", ovf_b);
        end
        checks++;
        if (bcd_b !== {12'h000, 12'h511}) begin
            errors++;
            $display("[TB] FAIL sat_bcd: got %h want %h", bcd_b, {12'h000, 12'h511});
        end
    endtask

    task automatic test_clip();
        int at_c;
        rst_c = 1'b1;
        rel_c = cyc;
        wait_rel(rel_c, 10);
        pulses_c(1500);
        wait_dv(2, rel_c, GATE_C + 100, at_c);
        checks++;
        if (at_c !== GATE_C - 1 + CONV) begin
            errors++;
            $display("[TB] FAIL clip_dv_time: got %0d want %0d", at_c, GATE_C - 1 + CONV);
        end
        checks++;
        if (bin_c !== {12'd0, 12'd1500}) begin
            errors++;
            $display("[TB] FAIL clip_bin: got %h want %h", bin_c, {12'd0, 12'd1500});
        end
        checks++;
        if (bcd_c[11:0] !== 12'h999) begin
            errors++;
            $display("[TB] FAIL clip_bcd: got %h want 999", bcd_c[11:0]);
        end
        checks++;
        if (ovf_c !== 2'b00) begin
            errors++;
            $display("[TB] FAIL clip_ovf: got %b want 00", ovf_c);
        end
    endtask

    initial begin
        rst_a   = 1'b0;
        rst_b   = 1'b0;
        rst_c   = 1'b0;
        pulse_a = 2'b00;
        pulse_b = 2'b00;
        pulse_c = 2'b00;
        rel_a   = 0;
        rel_b   = 0;
        rel_c   = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_we_boundary();
        test_reset_abort();
        test_glitch();
        rst_a = 1'b0;
        test_saturate();
        rst_b = 1'b0;
        test_clip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/speed_meter_nch.md
SPEED_METER_NCH -- requirements
Module: speed_meter_nch

Interface
REQ-001 Parameter N_CH, default 2: number of independent pulse channels (1..8).
REQ-002 Parameter CNT_W, default 12: width of each per-channel pulse counter (10..16).
REQ-003 Parameter GATE_CYCLES, default 100000000: measurement window length in clk_in cycles; it SHALL exceed N_CH*11+4.
REQ-004 Parameter SHIFT, default 1: right-shift applied to the raw count before BCD display conversion (0..4).
REQ-005 Port clk_in, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port speed_pulse, input, N_CH bits: asynchronous encoder pulse per channel; bit i is channel i.
REQ-008 Port speed_bin, output, N_CH*CNT_W bits: latched raw count per channel; channel i is at bits [i*CNT_W +: CNT_W].
REQ-009 Port speed_bcd, output, N_CH*12 bits: three BCD digits (hundreds, tens, ones) per channel; channel i is at bits [i*12 +: 12].
REQ-010 Port ovf, output, N_CH bits: the counter for that channel saturated during the last completed window.
REQ-011 Port data_valid, output, 1 bit: one-cycle pulse marking that speed_bcd has been updated.

Function
REQ-012 Each speed_pulse bit SHALL pass through a 2-flop synchronizer, followed by a rising-edge detector (sync edge = current synchronized sample high, previous sample low).
REQ-013 Gate counter SHALL count 0..GATE_CYCLES-1 and wrap; the cycle where it equals GATE_CYCLES-1 is the window-end cycle (WE).
REQ-014 Outside WE, each channel counter SHALL increment on a sync edge and saturate at 2^CNT_W-1; a saturated channel's sticky overflow bit is set.
REQ-015 At WE, speed_bin[i] SHALL load (counter + edge in WE), saturated, and ovf[i] SHALL load the sticky bit (or saturation occurring at WE).
REQ-016 At WE, counters and sticky bits SHALL clear to 0, so an edge in cycle WE+1 counts into the new window; no edge is lost or double-counted.
REQ-017 The conversion FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
- IDLE -> LOAD on WE; channel index = 0.
- LOAD: take the operand min(speed_bin[idx] >> SHIFT, 999) as 10 bits, clear the BCD scratch, then go to SHIFT.
- SHIFT: 10 iterations of double-dabble (add 3 to any digit >= 5, then shift left 1).
- After the 10th iteration: write the result into speed_bcd[idx]. If idx < N_CH-1, increment idx and go to LOAD; otherwise go to DONE.
- DONE: assert data_valid for one cycle, then go to IDLE.
REQ-018 data_valid SHALL assert exactly N_CH*11+1 cycles after the WE cycle; pulse counting continues unaffected during conversion.
REQ-019 speed_bcd SHALL update channel-by-channel during conversion; consumers sample it only on data_valid.

Reset
REQ-020 While rst_n is low at a clk_in edge, all of the following SHALL clear to 0: gate counter, channel counters, synchronizers, edge history, speed_bin, speed_bcd, ovf and data_valid. The FSM SHALL return to IDLE.
REQ-021 Reset during a conversion SHALL abort it with no data_valid pulse; the first window after release is a full GATE_CYCLES window.

Configuration
REQ-022 Macro SPEED_DEBOUNCE_EN:
- Defined: a 4-cycle glitch filter sits between the synchronizer and the edge detector. The filtered level changes only after 4 consecutive equal synchronized samples, which adds 4 cycles of edge latency.
- Undefined: no filter, and edge latency is 2 cycles from the pin.

Verification
REQ-023 The bench SHALL cover the following directed scenarios, with N_CH=2, GATE_CYCLES=1000, CNT_W=12, SHIFT=1 unless stated:
- Ch0 gets 200 clean pulses and ch1 gets 57 in one window -> speed_bin = 200/57, speed_bcd ch0 = 0x100, ch1 = 0x028, data_valid at WE+23, ovf = 0.
- CNT_W=10, ch0 gets 1100 edges (GATE_CYCLES=5000) -> speed_bin ch0 = 1023, ovf[0] = 1, speed_bcd ch0 = 0x511.
- SHIFT=0, count 1500 -> speed_bcd = 0x999 (clipped); speed_bin = 1500.
- Edges exactly at WE and at WE+1 -> the WE edge is in the old window's count and the WE+1 edge is in the new window; totals match the pulses sent.
- rst_n low at WE+5 for 1 cycle -> no data_valid; all outputs 0; the next data_valid arrives 1000+23 cycles after release.
- SPEED_DEBOUNCE_EN defined, 2-cycle glitches plus 10 clean pulses -> count = 10; undefined -> glitches counted.
